// File: rtl/daq_event_reader.sv
// Drains complete events from the DAQ event buffer onto a valid/ready stream,
// releasing each buffer page with an advance-read write once its last word is accepted.
module daq_event_reader #(
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned MAX_WORDS = 2047
) (
    input  logic        axi_clk,
    input  logic        reset,
    input  logic        enable,
    output logic        axi_rstr,
    output logic [11:0] axi_raddr,
    input  logic        axi_rack,
    input  logic [31:0] axi_dout,
    output logic        axi_wstr,
    output logic [11:0] axi_waddr,
    output logic [31:0] axi_din,
    input  logic        axi_wack,
    output logic [31:0] evt_data,
    output logic        evt_valid,
    output logic        evt_last,
    input  logic        evt_ready,
    output logic [15:0] evt_count,
    output logic        trunc_err,
    output logic        busy
);

    localparam logic [11:0] StatusAddr = 12'h041;
    localparam logic [11:0] AdvAddr    = 12'h001;
    localparam logic [31:0] AdvCmd     = 32'h0000_0002;
    localparam logic [10:0] MaxWords   = 11'(MAX_WORDS);
    localparam logic [7:0]  PollGap    = 8'(POLL_GAP);

    // *Req states hold the strobe until ack; *Rel states wait for the ack to fall.
    typedef enum logic [3:0] {
        StIdle,
        StPollReq,
        StPollRel,
        StGap,
        StFetchReq,
        StFetchRel,
        StPush,
        StAdvReq,
        StAdvRel
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [10:0] words_q, words_d;
    logic [10:0] index_q, index_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] count_q, count_d;
    logic        trunc_q, trunc_d;

    logic [10:0] status_len;
    logic [10:0] words_min;
    logic        is_last;

    // word_q doubles as the status capture so the decode happens once ack has fallen.
    assign status_len = word_q[26:16];
    assign words_min  = (status_len > MaxWords) ? MaxWords : status_len;
    assign is_last    = (index_q == words_q - 11'd1);

    always_ff @(posedge axi_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            words_q <= '0;
            index_q <= '0;
            gap_q   <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            words_q <= words_d;
            index_q <= index_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        words_d = words_q;
        index_d = index_q;
        gap_d   = gap_q;
        count_d = count_q;
        trunc_d = trunc_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StPollReq;
            end
            StPollReq: begin
                if (axi_rack) begin
                    word_d  = axi_dout;
                    state_d = StPollRel;
                end
            end
            StPollRel: begin
                if (!axi_rack) begin
                    if (word_q[0]) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        words_d = words_min;
                        index_d = '0;
                        if (status_len > MaxWords) trunc_d = 1'b1;
                        state_d = (words_min == 11'd0) ? StAdvReq : StFetchReq;
                    end
                end
            end
            StGap: begin
                if (gap_q == PollGap) state_d = StIdle;
                else gap_d = gap_q + 8'd1;
            end
            StFetchReq: begin
                if (axi_rack) begin
                    word_d  = axi_dout;
                    state_d = StFetchRel;
                end
            end
            StFetchRel: begin
                if (!axi_rack) state_d = StPush;
            end
            StPush: begin
                if (evt_ready) begin
                    index_d = index_q + 11'd1;
                    state_d = is_last ? StAdvReq : StFetchReq;
                end
            end
            StAdvReq: begin
                if (axi_wack) state_d = StAdvRel;
            end
            StAdvRel: begin
                if (!axi_wack) begin
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign axi_rstr  = (state_q == StPollReq) || (state_q == StFetchReq);
    assign axi_raddr = (state_q == StPollReq)  ? StatusAddr :
                       (state_q == StFetchReq) ? {1'b1, index_q} : 12'h000;
    assign axi_wstr  = (state_q == StAdvReq);
    assign axi_waddr = axi_wstr ? AdvAddr : 12'h000;
    assign axi_din   = axi_wstr ? AdvCmd : 32'h0;
    assign evt_valid = (state_q == StPush);
    assign evt_data  = evt_valid ? word_q : 32'h0;
    assign evt_last  = evt_valid && is_last;
    assign evt_count = count_q;
    assign trunc_err = trunc_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_daq_event_reader.sv
// Self-checking bench: a behavioural event-buffer model answers the bus, and the
// expected stream is built from each queued event's length and payload.
module tb_daq_event_reader;

    localparam int unsigned TB_GAP = 16;
    localparam int unsigned TB_MAX = 6;

    logic        axi_clk;
    logic        reset;
    logic        enable;
    logic        axi_rstr;
    logic [11:0] axi_raddr;
    logic        axi_rack;
    logic [31:0] axi_dout;
    logic        axi_wstr;
    logic [11:0] axi_waddr;
    logic [31:0] axi_din;
    logic        axi_wack;
    logic [31:0] evt_data;
    logic        evt_valid;
    logic        evt_last;
    logic        evt_ready;
    logic [15:0] evt_count;
    logic        trunc_err;
    logic        busy;

    daq_event_reader #(
        .POLL_GAP (TB_GAP),
        .MAX_WORDS(TB_MAX)
    ) dut (
        .axi_clk  (axi_clk),
        .reset    (reset),
        .enable   (enable),
        .axi_rstr (axi_rstr),
        .axi_raddr(axi_raddr),
        .axi_rack (axi_rack),
        .axi_dout (axi_dout),
        .axi_wstr (axi_wstr),
        .axi_waddr(axi_waddr),
        .axi_din  (axi_din),
        .axi_wack (axi_wack),
        .evt_data (evt_data),
        .evt_valid(evt_valid),
        .evt_last (evt_last),
        .evt_ready(evt_ready),
        .evt_count(evt_count),
        .trunc_err(trunc_err),
        .busy     (busy)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    logic [109:0] all_outs;
    assign all_outs = {axi_rstr, axi_raddr, axi_wstr, axi_waddr, axi_din, evt_data,
                       evt_valid, evt_last, evt_count, trunc_err, busy};

    // Buffer model: ring of pages, each with a length and up to 16 payload words.
    logic [31:0] mem [0:31][0:15];
    int          ev_len [0:31];
    int          head = 0;
    int          tail = 0;

    // Reference model of what the stream and counters should show.
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    int          exp_count = 0;
    bit          exp_trunc = 0;

    // Observations from the bus and stream.
    logic [31:0] cap_data[$];
    bit          cap_last[$];
    logic [43:0] wr_log[$];
    int          poll_times[$];
    int          wr_count = 0;
    int          stall_err = 0;
    int          overlap_err = 0;
    int          order_err = 0;

    int          ready_mode = 0;
    int          ready_limit = 0;
    int          pat_i = 0;
    bit          pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int          rcnt = 0, rlat = 4, wcnt = 0, wlat = 4;
    logic        prev_rstr = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    function automatic logic [31:0] buf_read(input logic [11:0] addr);
        logic [31:0] s;
        int          idx;
        if (addr == 12'h041) begin
            s = $urandom & 32'hF800_FFFE;
            if (head == tail) s[0] = 1'b1;
            else s[26:16] = 11'(ev_len[head % 32]);
            return s;
        end
        if (addr[11]) begin
            idx = int'(addr[10:0]);
            return (idx < 16) ? mem[head % 32][idx] : 32'hBAD0_0000;
        end
        return 32'hDEAD_BEEF;
    endfunction

    // All bench-side drives and samples happen on the falling edge.
    always @(negedge axi_clk) begin
        if (axi_rstr) begin
            if (!axi_rack) begin
                rcnt++;
                if (rcnt >= rlat) begin
                    axi_rack = 1'b1;
                    axi_dout = buf_read(axi_raddr);
                end
            end
        end else begin
            axi_rack = 1'b0;
            axi_dout = 32'h0;
            rcnt = 0;
            rlat = int'($urandom_range(1, 5));
        end
        if (axi_wstr) begin
            if (!axi_wack) begin
                wcnt++;
                if (wcnt >= wlat) begin
                    axi_wack = 1'b1;
                    wr_log.push_back({axi_waddr, axi_din});
                    wr_count++;
                    if (axi_waddr == 12'h001 && axi_din == 32'h2 && head != tail) head++;
                end
            end
        end else begin
            axi_wack = 1'b0;
            wcnt = 0;
            wlat = int'($urandom_range(1, 5));
        end
        if (axi_rstr && axi_wstr) overlap_err++;
        if (axi_rstr && !prev_rstr && axi_raddr == 12'h041) begin
            poll_times.push_back(cyc);
            if (axi_wack) order_err++;
        end
        prev_rstr = axi_rstr;

        case (ready_mode)
            1:       begin evt_ready = pat[pat_i % 4]; pat_i++; end
            2:       evt_ready = 1'($urandom_range(0, 1));
            3:       evt_ready = (cap_data.size() < ready_limit);
            default: evt_ready = 1'b1;
        endcase
        if (prev_stall && (!evt_valid || evt_data !== prev_d || evt_last !== prev_l)) stall_err++;
        if (evt_valid && evt_ready) begin
            cap_data.push_back(evt_data);
            cap_last.push_back(evt_last);
        end
        prev_stall = evt_valid && !evt_ready;
        prev_d = evt_data;
        prev_l = evt_last;
    end

    task automatic expect_slot(input int slot);
        int n;
        n = (ev_len[slot] > int'(TB_MAX)) ? int'(TB_MAX) : ev_len[slot];
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(mem[slot][i]);
            exp_last.push_back(i == n - 1);
        end
        if (ev_len[slot] > int'(TB_MAX)) exp_trunc = 1'b1;
        exp_count++;
    endtask

    task automatic add_event(input int len, input logic [31:0] base, input bit rnd,
                             input bit expect_it);
        int slot;
        slot = tail % 32;
        ev_len[slot] = len;
        for (int i = 0; i < 16; i++) mem[slot][i] = rnd ? $urandom : base + 32'(i);
        tail++;
        if (expect_it) expect_slot(slot);
    endtask

    task automatic clear_obs();
        cap_data.delete();
        cap_last.delete();
        exp_data.delete();
        exp_last.delete();
        stall_err = 0;
    endtask

    task automatic wait_writes(input int n, input int budget, input int settle, output bit ok);
        int k;
        k = 0;
        while (wr_count < n && k < budget) begin
            @(negedge axi_clk);
            k++;
        end
        ok = (wr_count >= n);
        repeat (settle) @(negedge axi_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge axi_clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        reset = 1'b0;
        repeat (5) @(negedge axi_clk);
        checks++;
        if ({busy, axi_rstr, evt_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_when_disabled: busy/rstr/valid=%b required 000",
                     {busy, axi_rstr, evt_valid});
        end
    endtask

    task automatic test_single_event();
        bit ok;
        int w0;
        clear_obs();
        w0 = wr_count;
        add_event(3, 32'hA0, 1'b0, 1'b1);
        enable = 1'b1;
        wait_writes(w0 + 1, 400, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: writes=%0d required=%0d",
                                          wr_count, w0 + 1); end
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL single_len: got %0d words required %0d", cap_data.size(),
                     exp_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL single_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (wr_count != w0 + 1 || wr_log[wr_log.size() - 1] !== {12'h001, 32'h2}) begin
            errors++;
            $display("FAIL single_advance: writes=%0d last=%h required %0d writes of 001/2",
                     wr_count - w0, wr_log[wr_log.size() - 1], 1);
        end
        checks++;
        if (evt_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL single_count: got %0d required %0d", evt_count, exp_count);
        end
    endtask

    task automatic test_empty_poll();
        int w0;
        clear_obs();
        poll_times.delete();
        w0 = wr_count;
        enable = 1'b1;
        repeat (250) @(negedge axi_clk);
        checks++;
        if (poll_times.size() < 3) begin
            errors++;
            $display("FAIL empty_polls: got %0d polls required >=3", poll_times.size());
        end
        for (int i = 1; i < poll_times.size(); i++) begin
            checks++;
            if (poll_times[i] - poll_times[i-1] < int'(TB_GAP)) begin
                errors++;
                $display("FAIL empty_gap%0d: got %0d cycles required >=%0d", i,
                         poll_times[i] - poll_times[i-1], TB_GAP);
            end
        end
        checks++;
        if (cap_data.size() != 0 || wr_count != w0) begin
            errors++;
            $display("FAIL empty_quiet: got %0d words %0d writes required 0 0",
                     cap_data.size(), wr_count - w0);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int w0;
        clear_obs();
        w0 = wr_count;
        pat_i = 0;
        ready_mode = 1;
        add_event(4, 32'h0, 1'b1, 1'b1);
        wait_writes(w0 + 1, 800, 10, ok);
        ready_mode = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: writes=%0d required=%0d",
                                          wr_count, w0 + 1); end
        checks++;
        if (cap_data.size() != 4) begin
            errors++;
            $display("FAIL stall_handshakes: got %0d required 4", cap_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL stall_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d changes while stalled required 0", stall_err);
        end
    endtask

    task automatic test_trunc();
        bit ok;
        int w0;
        clear_obs();
        w0 = wr_count;
        add_event(9, 32'h0, 1'b1, 1'b1);
        add_event(2, 32'h0, 1'b1, 1'b1);
        wait_writes(w0 + 2, 1000, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL trunc_timeout: writes=%0d required=%0d",
                                          wr_count, w0 + 2); end
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL trunc_len: got %0d words required %0d", cap_data.size(),
                     exp_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL trunc_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (trunc_err !== exp_trunc || evt_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL trunc_flag: got trunc=%b count=%0d required trunc=%b count=%0d",
                     trunc_err, evt_count, exp_trunc, exp_count);
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        int w0;
        int c0;
        clear_obs();
        w0 = wr_count;
        c0 = exp_count;
        add_event(0, 32'h0, 1'b1, 1'b1);
        add_event(2, 32'hC0, 1'b0, 1'b1);
        wait_writes(w0 + 1, 400, 3, ok);
        checks++;
        if (!ok || cap_data.size() != 0 || evt_count !== 16'(c0 + 1)) begin
            errors++;
            $display("FAIL zero_first: got ok=%b words=%0d count=%0d required 1 0 %0d",
                     ok, cap_data.size(), evt_count, c0 + 1);
        end
        wait_writes(w0 + 2, 600, 10, ok);
        checks++;
        if (!ok || cap_data.size() != 2) begin
            errors++;
            $display("FAIL zero_second: got ok=%b words=%0d required 1 2", ok, cap_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL zero_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (evt_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL zero_count: got %0d required %0d", evt_count, exp_count);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int w0;
        int k;
        clear_obs();
        w0 = wr_count;
        ready_limit = 1;
        ready_mode = 3;
        add_event(3, 32'hB0, 1'b0, 1'b0);
        k = 0;
        while (!(cap_data.size() == 1 && evt_valid) && k < 400) begin
            @(negedge axi_clk);
            k++;
        end
        checks++;
        if (!(cap_data.size() == 1 && evt_valid)) begin
            errors++;
            $display("FAIL rst_reach_word1: got words=%0d valid=%b required 1 1",
                     cap_data.size(), evt_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got %h required 0", all_outs);
        end
        repeat (3) @(negedge axi_clk);
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL rst_no_advance: got %0d writes required 0", wr_count - w0);
        end
        clear_obs();
        exp_count = 0;
        exp_trunc = 1'b0;
        expect_slot(head % 32);
        ready_mode = 0;
        reset = 1'b0;
        wait_writes(w0 + 1, 400, 10, ok);
        checks++;
        if (!ok || cap_data.size() != 3) begin
            errors++;
            $display("FAIL rst_reread: got ok=%b words=%0d required 1 3", ok, cap_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL rst_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (evt_count !== 16'(exp_count) || trunc_err !== exp_trunc) begin
            errors++;
            $display("FAIL rst_count: got count=%0d trunc=%b required %0d %b", evt_count,
                     trunc_err, exp_count, exp_trunc);
        end
    endtask

    task automatic test_enable_off();
        bit ok;
        int w0;
        int k;
        clear_obs();
        w0 = wr_count;
        add_event(3, 32'h0, 1'b1, 1'b1);
        add_event(3, 32'h0, 1'b1, 1'b0);
        k = 0;
        while (cap_data.size() < 1 && k < 400) begin
            @(negedge axi_clk);
            k++;
        end
        enable = 1'b0;
        wait_writes(w0 + 1, 400, 60, ok);
        checks++;
        if (!ok || cap_data.size() != 3 || wr_count != w0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enoff_stop: got ok=%b words=%0d writes=%0d busy=%b required 1 3 1 0",
                     ok, cap_data.size(), wr_count - w0, busy);
        end
        expect_slot(head % 32);
        enable = 1'b1;
        wait_writes(w0 + 2, 600, 10, ok);
        checks++;
        if (!ok || cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL enoff_resume: got ok=%b words=%0d required 1 %0d", ok,
                     cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL enoff_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int w0;
        int len;
        clear_obs();
        w0 = wr_count;
        ready_mode = 2;
        for (int e = 0; e < 8; e++) begin
            len = (e == 3) ? int'(TB_MAX) : int'($urandom_range(0, 9));
            add_event(len, 32'h0, 1'b1, 1'b1);
        end
        wait_writes(w0 + 8, 6000, 10, ok);
        ready_mode = 0;
        checks++;
        if (!ok || cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL b2b_len: got ok=%b words=%0d required 1 %0d", ok, cap_data.size(),
                     exp_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
                errors++;
                $display("FAIL b2b_word%0d: got last=%b data=%h required last=%b data=%h", i,
                         cap_last[i], cap_data[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (evt_count !== 16'(exp_count) || trunc_err !== exp_trunc) begin
            errors++;
            $display("FAIL b2b_count: got count=%0d trunc=%b required %0d %b", evt_count,
                     trunc_err, exp_count, exp_trunc);
        end
        checks++;
        if (stall_err != 0 || overlap_err != 0 || order_err != 0) begin
            errors++;
            $display("FAIL b2b_protocol: got stall=%0d overlap=%0d order=%0d required 0 0 0",
                     stall_err, overlap_err, order_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        test_reset();
        test_single_event();
        test_empty_poll();
        test_stall();
        test_trunc();
        test_zero_len();
        test_async_reset();
        test_enable_off();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
